ps2_ascii: RTL
==============

# ps2_ascii

Keyboard front end for the text-console path. It receives raw PS/2 frames from the keyboard pins, decodes the scan-code set 2 make/break stream, and tracks Shift and Caps Lock. Each printable or editing keypress becomes a one-cycle `key_in`/`p_valid` strobe that drives the text video-memory writer directly.

## Interface
- `TIMEOUT`, default 50000: clk cycles without a ps2_clk falling edge before a partial frame is discarded.
- `clk`  input  1  system clock; all state updates on rising edge.
- `reset`  input  1  synchronous, active-low reset (`reset==0` at a rising clk edge resets the block).
- `ps2_clk`  input  1  keyboard clock pin, asynchronous.
- `ps2_data`  input  1  keyboard data pin, asynchronous.
- `key_in`  output  8  ASCII of the last emitted key; holds its value between strobes.
- `p_valid`  output  1  one-cycle strobe; `key_in` is valid in the same cycle.
- `frame_err`  output  1  one-cycle strobe on a bad start, stop or parity bit, or on a timeout.

## Operation
- **Input sync and edge detect**
  - `ps2_clk` and `ps2_data` each pass through a 3-flop synchronizer.
  - A falling edge is detected when the last two `ps2_clk` sync stages read 1 then 0.
  - `ps2_data` is sampled from the matching sync stage on that cycle.
- **Frame receiver**
  - 11-bit frame: start (0), 8 data bits LSB first, odd parity, stop (1).
  - A 4-bit counter (0..10) counts falling edges.
  - On edge 11 the frame is checked and the counter returns to 0.
  - Frame is good when start==0, stop==1 and the 9 bits data+parity have odd weight.
  - A good frame produces a one-cycle internal `code_vld` with the 8-bit code.
  - A bad frame pulses `frame_err` and produces no code.
- **Timeout**
  - The idle counter restarts on every falling edge.
  - If the frame counter is nonzero and the idle counter reaches `TIMEOUT`, the frame counter clears and `frame_err` pulses once.
- **Decoder FSM**, states NORMAL and BREAK, plus an `ext` flag.
  - **NORMAL**
    - code 0xE0: set `ext`, stay in NORMAL.
    - code 0xF0: go to BREAK.
    - any other code is a make code.
      - If `ext`==1: emit nothing, clear `ext`.
      - Otherwise: 0x12 or 0x59 sets `shift`; 0x58 toggles `caps`; a mapped key emits.
  - **BREAK**
    - Next code: 0x12 or 0x59 with `ext`==0 clears `shift`.
    - Always clear `ext` and return to NORMAL; never emit.
- **ASCII map**, unmapped make codes emit nothing.
  - Letters: 1C a, 32 b, 21 c, 23 d, 24 e, 2B f, 34 g, 33 h, 43 i, 3B j, 42 k, 4B l, 3A m, 31 n, 44 o, 4D p, 15 q, 2D r, 1B s, 2C t, 3C u, 2A v, 1D w, 22 x, 35 y, 1A z.
    - Uppercase when `shift` XOR `caps`.
  - Digits: 16 '1', 1E '2', 26 '3', 25 '4', 2E '5', 36 '6', 3D '7', 3E '8', 46 '9', 45 '0'.
    - With `shift` (Caps ignored): ! @ # $ % ^ & * ( ).
  - 0x29 gives 0x20 (space); 0x5A gives 0x0D (enter); 0x66 gives 0x08 (backspace).
    - These three ignore Shift and Caps.
- Typematic repeats arrive as repeated make codes; each one emits.

## Timing
- **Reset values:** `key_in`=0x00, `p_valid`=0, `frame_err`=0, FSM=NORMAL, `ext`=`shift`=`caps`=0, frame and idle counters 0, synchronizer flops 1.
- **Latency:** let cycle N be the clk edge at which the 11th falling edge is detected.
  - `code_vld` and `frame_err` (bad frame) are asserted in cycle N+1.
  - `p_valid` and the new `key_in` are asserted in cycle N+2.
- `p_valid` is high for exactly one cycle per emitted key.
  - At most one strobe per frame, so successive strobes are at least about 11 PS/2 bit periods apart.
  - There is no back-pressure; the consumer must accept every strobe.
- **Simultaneous events:** a falling edge in the same cycle the idle counter hits `TIMEOUT` counts as an edge; no timeout fires.
- **Reset mid-frame:** a partial frame is dropped, and the next frame is received only from its start bit.
  - Bits that arrive before the keyboard goes idle form a misaligned frame; it is rejected by the checks or by timeout.
- The `shift` change from 0x12 or 0x59 applies to the next make code, not the same frame.

## Test plan
- Reset, then frame 0x1C, then frame 0x1C: `p_valid` two times, each with `key_in`=0x61, each pulse exactly 2 cycles after the stop-bit edge; `frame_err` stays 0.
- Frames 12, 1C, F0 1C, F0 12, 1C: emits 0x41 then 0x61; nothing emitted on the break codes.
- Frames 58, F0 58, 1C, 12, 1C, 16: emits 0x41 (caps), 0x61 (caps^shift), 0x21 '!'.
- Frames 5A, 66, 29, E0 75, E0 F0 75: emits 0x0D, 0x08, 0x20; no strobe for the extended up-arrow.
- Frame 0x1C with bad parity, then a 5-bit partial frame followed by idle > `TIMEOUT`: two single-cycle `frame_err` pulses, no `p_valid`; the following good 0x32 emits 0x62.
- Assert reset (0) after 6 bits of a frame, release, then send a full 0x45: no spurious strobe; emits 0x30, and `shift`/`caps` read as cleared.

Source files
------------

// File: rtl/ps2_ascii.sv
`default_nettype none
// ============================================================================
// Module      : ps2_ascii
// Description : PS/2 scan-code set 2 receiver and decoder producing one ASCII
//               strobe per printable/editing keypress, with Shift/Caps state.
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_ascii #(
    parameter int TIMEOUT = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] key_in,
    output logic       p_valid,
    output logic       frame_err
);

    localparam int                  c_IDLE_W   = $clog2(TIMEOUT + 1);
    localparam logic [c_IDLE_W-1:0] c_IDLE_MAX = c_IDLE_W'(TIMEOUT);
    localparam logic [3:0]          c_LAST_BIT = 4'd10;

    typedef enum logic [0:0] {
        ST_NORMAL = 1'b0,
        ST_BREAK  = 1'b1
    } state_t;

    logic [2:0]          r_clk_sync;
    logic [2:0]          r_data_sync;
    logic                w_fall;
    logic                w_data_bit;
    logic [3:0]          r_bit_cnt;
    logic [9:0]          r_shreg;
    logic [c_IDLE_W-1:0] r_idle_cnt;
    logic                w_frame_ok;
    logic                w_timeout;
    logic                r_code_vld;
    logic [7:0]          r_code;
    logic                r_frame_err;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_ext;
    logic                w_ext_nxt;
    logic                r_shift;
    logic                w_shift_nxt;
    logic                r_caps;
    logic                w_caps_nxt;
    logic [7:0]          r_key;
    logic [7:0]          w_key_nxt;
    logic                r_pvalid;
    logic                w_pvalid_nxt;
    logic [8:0]          w_map;

    assign w_fall     = r_clk_sync[2] & ~r_clk_sync[1];
    assign w_data_bit = r_data_sync[1];
    // r_shreg holds start in [0], data in [8:1], parity in [9]; stop is the live bit
    assign w_frame_ok = ~r_shreg[0] & w_data_bit & (^r_shreg[9:1]);
    assign w_timeout  = !w_fall && (r_bit_cnt != 4'd0) && (r_idle_cnt == c_IDLE_MAX);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_clk_sync  <= 3'b111;
            r_data_sync <= 3'b111;
        end else begin
            r_clk_sync  <= {r_clk_sync[1:0], ps2_clk};
            r_data_sync <= {r_data_sync[1:0], ps2_data};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_bit_cnt   <= 4'd0;
            r_shreg     <= 10'd0;
            r_idle_cnt  <= '0;
            r_code_vld  <= 1'b0;
            r_code      <= 8'h00;
            r_frame_err <= 1'b0;
        end else begin
            r_code_vld  <= 1'b0;
            r_frame_err <= 1'b0;
            if (w_fall) begin
                r_idle_cnt <= '0;
                r_shreg    <= {w_data_bit, r_shreg[9:1]};
                if (r_bit_cnt == c_LAST_BIT) begin
                    r_bit_cnt <= 4'd0;
                    if (w_frame_ok) begin
                        r_code_vld <= 1'b1;
                        r_code     <= r_shreg[8:1];
                    end else begin
                        r_frame_err <= 1'b1;
                    end
                end else begin
                    r_bit_cnt <= r_bit_cnt + 4'd1;
                end
            end else begin
                // saturate so a long idle line never wraps back into a false timeout
                if (r_idle_cnt != c_IDLE_MAX) begin
                    r_idle_cnt <= r_idle_cnt + c_IDLE_W'(1);
                end
                if (w_timeout) begin
                    r_bit_cnt   <= 4'd0;
                    r_frame_err <= 1'b1;
                end
            end
        end
    end

    // Returns {hit, ascii}; hit is 0 for make codes with no character.
    function automatic logic [8:0] map_key(input logic [7:0] code,
                                           input logic       shift,
                                           input logic       caps);
        logic [7:0] letter;
        logic [7:0] digit;
        logic [7:0] digit_sh;
        logic [7:0] fixed;
        letter   = 8'h00;
        digit    = 8'h00;
        digit_sh = 8'h00;
        fixed    = 8'h00;
        case (code)
            8'h1C: letter = "a";
            8'h32: letter = "b";
            8'h21: letter = "c";
            8'h23: letter = "d";
            8'h24: letter = "e";
            8'h2B: letter = "f";
            8'h34: letter = "g";
            8'h33: letter = "h";
            8'h43: letter = "i";
            8'h3B: letter = "j";
            8'h42: letter = "k";
            8'h4B: letter = "l";
            8'h3A: letter = "m";
            8'h31: letter = "n";
            8'h44: letter = "o";
            8'h4D: letter = "p";
            8'h15: letter = "q";
            8'h2D: letter = "r";
            8'h1B: letter = "s";
            8'h2C: letter = "t";
            8'h3C: letter = "u";
            8'h2A: letter = "v";
            8'h1D: letter = "w";
            8'h22: letter = "x";
            8'h35: letter = "y";
            8'h1A: letter = "z";
            8'h16: begin digit = "1"; digit_sh = "!"; end
            8'h1E: begin digit = "2"; digit_sh = "@"; end
            8'h26: begin digit = "3"; digit_sh = "#"; end
            8'h25: begin digit = "4"; digit_sh = "$"; end
            8'h2E: begin digit = "5"; digit_sh = "%"; end
            8'h36: begin digit = "6"; digit_sh = "^"; end
            8'h3D: begin digit = "7"; digit_sh = "&"; end
            8'h3E: begin digit = "8"; digit_sh = "*"; end
            8'h46: begin digit = "9"; digit_sh = "("; end
            8'h45: begin digit = "0"; digit_sh = ")"; end
            8'h29: fixed = 8'h20;
            8'h5A: fixed = 8'h0D;
            8'h66: fixed = 8'h08;
            default: ;
        endcase
        if (letter != 8'h00) begin
            map_key = {1'b1, (shift ^ caps) ? (letter - 8'h20) : letter};
        end else if (digit != 8'h00) begin
            map_key = {1'b1, shift ? digit_sh : digit};
        end else if (fixed != 8'h00) begin
            map_key = {1'b1, fixed};
        end else begin
            map_key = 9'h000;
        end
    endfunction

    assign w_map = map_key(r_code, r_shift, r_caps);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state  <= ST_NORMAL;
            r_ext    <= 1'b0;
            r_shift  <= 1'b0;
            r_caps   <= 1'b0;
            r_key    <= 8'h00;
            r_pvalid <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_ext    <= w_ext_nxt;
            r_shift  <= w_shift_nxt;
            r_caps   <= w_caps_nxt;
            r_key    <= w_key_nxt;
            r_pvalid <= w_pvalid_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_ext_nxt    = r_ext;
        w_shift_nxt  = r_shift;
        w_caps_nxt   = r_caps;
        w_key_nxt    = r_key;
        w_pvalid_nxt = 1'b0;
        if (r_code_vld) begin
            case (r_state)
                ST_NORMAL: begin
                    if (r_code == 8'hE0) begin
                        w_ext_nxt = 1'b1;
                    end else if (r_code == 8'hF0) begin
                        w_state_nxt = ST_BREAK;
                    end else if (r_ext) begin
                        w_ext_nxt = 1'b0;
                    end else if (r_code == 8'h12 || r_code == 8'h59) begin
                        w_shift_nxt = 1'b1;
                    end else if (r_code == 8'h58) begin
                        w_caps_nxt = ~r_caps;
                    end else if (w_map[8]) begin
                        w_key_nxt    = w_map[7:0];
                        w_pvalid_nxt = 1'b1;
                    end
                end
                ST_BREAK: begin
                    if (!r_ext && (r_code == 8'h12 || r_code == 8'h59)) begin
                        w_shift_nxt = 1'b0;
                    end
                    w_ext_nxt   = 1'b0;
                    w_state_nxt = ST_NORMAL;
                end
                default: w_state_nxt = ST_NORMAL;
            endcase
        end
    end

    assign key_in    = r_key;
    assign p_valid   = r_pvalid;
    assign frame_err = r_frame_err;

endmodule
`default_nettype wire
